// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        MODE_VBAR  = 3'd0,
        MODE_HBAR  = 3'd1,
        MODE_CHECK = 3'd2,
        MODE_GRAD  = 3'd3,
        MODE_BOX   = 3'd4,
        MODE_SOLID = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } mode_t;

    localparam rgb565_t RGB_WHITE   = 16'hFFFF;
    localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
    localparam rgb565_t RGB_CYAN    = 16'h07FF;
    localparam rgb565_t RGB_GREEN   = 16'h07E0;
    localparam rgb565_t RGB_MAGENTA = 16'hF81F;
    localparam rgb565_t RGB_RED     = 16'hF800;
    localparam rgb565_t RGB_BLUE    = 16'h001F;
    localparam rgb565_t RGB_BLACK   = 16'h0000;

    // Eight-entry colour-bar palette, white first, black last.
    function automatic rgb565_t palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = RGB_WHITE;
            3'd1:    palette = RGB_YELLOW;
            3'd2:    palette = RGB_CYAN;
            3'd3:    palette = RGB_GREEN;
            3'd4:    palette = RGB_MAGENTA;
            3'd5:    palette = RGB_RED;
            3'd6:    palette = RGB_BLUE;
            default: palette = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle between timing generator, pattern source and output path.
// Latency: n/a (wiring only).
// Backpressure: none; the pixel stream is free-running.
interface vga_pattern_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    import vga_pkg::*;

    logic          de;
    logic [XW-1:0] X;
    logic [YW-1:0] Y;
    logic [2:0]    mode_in;
    logic          mode_wr;
    rgb565_t       data_rgb;
    logic          data_de;
    logic [7:0]    frame_cnt;

    modport master (
        output de, X, Y, mode_in, mode_wr,
        input  data_rgb, data_de, frame_cnt
    );

    modport slave (
        input  de, X, Y, mode_in, mode_wr,
        output data_rgb, data_de, frame_cnt
    );
endinterface

// File: rtl/vga_box_anim.sv
// Bouncing-box position state, one step per frame on each axis.
// Latency: new position visible the cycle after frame_end.
// Backpressure: none; frame_end is a single-cycle event.
module vga_box_anim #(
    parameter int H_ADDR   = 640,
    parameter int V_ADDR   = 480,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 4
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          frame_end,
    output logic [XW-1:0] box_x,
    output logic [YW-1:0] box_y
);
    // One extra bit so position+step never wraps before the clamp compare.
    localparam logic [XW:0] MAXX   = (XW+1)'(H_ADDR - BOX_SIZE);
    localparam logic [YW:0] MAXY   = (YW+1)'(V_ADDR - BOX_SIZE);
    localparam logic [XW:0] STEP_X = (XW+1)'(BOX_STEP);
    localparam logic [YW:0] STEP_Y = (YW+1)'(BOX_STEP);

    logic        dir_x_pos;
    logic        dir_y_pos;
    logic [XW:0] next_x;
    logic [YW:0] next_y;

    assign next_x = {1'b0, box_x} + STEP_X;
    assign next_y = {1'b0, box_y} + STEP_Y;

    // Horizontal bounce: clamp to the edge and reverse on reaching either limit.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            box_x     <= '0;
            dir_x_pos <= 1'b1;
        end else if (frame_end) begin
            if (dir_x_pos) begin
                if (next_x >= MAXX) begin
                    box_x     <= MAXX[XW-1:0];
                    dir_x_pos <= 1'b0;
                end else begin
                    box_x <= next_x[XW-1:0];
                end
            end else if ({1'b0, box_x} <= STEP_X) begin
                box_x     <= '0;
                dir_x_pos <= 1'b1;
            end else begin
                box_x <= box_x - STEP_X[XW-1:0];
            end
        end
    end

    // Vertical bounce, same rule against the bottom limit.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            box_y     <= '0;
            dir_y_pos <= 1'b1;
        end else if (frame_end) begin
            if (dir_y_pos) begin
                if (next_y >= MAXY) begin
                    box_y     <= MAXY[YW-1:0];
                    dir_y_pos <= 1'b0;
                end else begin
                    box_y <= next_y[YW-1:0];
                end
            end else if ({1'b0, box_y} <= STEP_Y) begin
                box_y     <= '0;
                dir_y_pos <= 1'b1;
            end else begin
                box_y <= box_y - STEP_Y[YW-1:0];
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode RGB565 test-pattern source driven by de/X/Y from the timing generator.
// Latency: data_rgb/data_de registered, 1 pclk after de/X/Y.
// Backpressure: none; one pixel accepted and produced every pclk.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ADDR   = 640,
    parameter int V_ADDR   = 480,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int BAR_NUM  = 8,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 4
) (
    input  logic               pclk,
    input  logic               rst_n,
    vga_pattern_gen_if.slave   bus
);
    localparam logic [XW-1:0] X_LAST   = XW'(H_ADDR - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ADDR - 1);
    localparam logic [XW-1:0] COL_LAST = XW'(H_ADDR / BAR_NUM - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(V_ADDR / BAR_NUM - 1);
    localparam logic [XW:0]   BOX_W    = (XW+1)'(BOX_SIZE);
    localparam logic [YW:0]   BOX_H    = (YW+1)'(BOX_SIZE);

    mode_t         pending_mode;
    mode_t         active_mode;
    logic [7:0]    frame_cnt;
    logic          frame_end;
    logic          line_start;
    logic          line_last;
    logic          top_row;
    logic [XW-1:0] col_cnt, col_cur;
    logic [2:0]    bar_idx, bar_cur;
    logic [YW-1:0] row_cnt, row_cur;
    logic [2:0]    row_idx, row_bar;
    logic [XW-1:0] box_x;
    logic [YW-1:0] box_y;
    logic          in_box;
    rgb565_t       pix;

    assign frame_end  = bus.de && (bus.X == X_LAST) && (bus.Y == Y_LAST);
    assign line_start = bus.de && (bus.X == '0);
    assign line_last  = bus.de && (bus.X == X_LAST);
    assign top_row    = (bus.Y == '0);

    // Counters are forced to zero on the first pixel of a line / first line of a
    // frame, so a mid-frame reset or skipped pixels self-heal at the next boundary.
    assign col_cur = line_start ? '0 : col_cnt;
    assign bar_cur = line_start ? '0 : bar_idx;
    assign row_cur = top_row ? '0 : row_cnt;
    assign row_bar = top_row ? '0 : row_idx;

    vga_box_anim #(
        .H_ADDR  (H_ADDR),
        .V_ADDR  (V_ADDR),
        .XW      (XW),
        .YW      (YW),
        .BOX_SIZE(BOX_SIZE),
        .BOX_STEP(BOX_STEP)
    ) u_box (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .frame_end(frame_end),
        .box_x    (box_x),
        .box_y    (box_y)
    );

    assign in_box = (bus.X >= box_x) && ({1'b0, bus.X} < ({1'b0, box_x} + BOX_W)) &&
                    (bus.Y >= box_y) && ({1'b0, bus.Y} < ({1'b0, box_y} + BOX_H));

    // Mode shadow: writes land in pending; active follows only at frame_end,
    // taking mode_in directly when the write coincides with frame_end.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            pending_mode <= MODE_VBAR;
            active_mode  <= MODE_VBAR;
            frame_cnt    <= '0;
        end else begin
            if (bus.mode_wr) pending_mode <= mode_t'(bus.mode_in);
            if (frame_end) begin
                active_mode <= bus.mode_wr ? mode_t'(bus.mode_in) : pending_mode;
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    // Vertical-bar tracking: column within the bar and bar index, stepped per active pixel.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            bar_idx <= '0;
        end else if (bus.de) begin
            if (col_cur == COL_LAST) begin
                col_cnt <= '0;
                bar_idx <= bar_cur + 3'd1;
            end else begin
                col_cnt <= col_cur + XW'(1);
                bar_idx <= bar_cur;
            end
        end
    end

    // Horizontal-bar tracking: line within the band and band index, stepped per line.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            row_cnt <= '0;
            row_idx <= '0;
        end else if (line_last) begin
            if (row_cur == ROW_LAST) begin
                row_cnt <= '0;
                row_idx <= row_bar + 3'd1;
            end else begin
                row_cnt <= row_cur + YW'(1);
                row_idx <= row_bar;
            end
        end
    end

    // Pattern mux for the pixel currently presented on X/Y.
    always_comb begin
        pix = RGB_BLACK;
        case (active_mode)
            MODE_VBAR:  pix = palette(bar_cur);
            MODE_HBAR:  pix = palette(row_bar);
            MODE_CHECK: pix = (bus.X[CHK_LOG2] ^ bus.Y[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            MODE_GRAD:  pix = {bus.X[XW-1-:5], bus.Y[YW-1-:6], frame_cnt[7:3]};
            MODE_BOX:   pix = in_box ? RGB_WHITE : RGB_BLUE;
            MODE_SOLID: pix = palette(frame_cnt[7:5]);
            default:    pix = RGB_BLACK;
        endcase
    end

    // Output register; blanking forces black.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            bus.data_rgb <= '0;
            bus.data_de  <= 1'b0;
        end else begin
            bus.data_rgb <= bus.de ? pix : RGB_BLACK;
            bus.data_de  <= bus.de;
        end
    end

    assign bus.frame_cnt = frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster so hundreds of frames fit.
// Latency: reference outputs compared one pclk after the stimulus cycle.
// Backpressure: none.
module tb_vga_pattern_gen;
    localparam int H  = 32;
    localparam int V  = 16;
    localparam int XW = 5;
    localparam int YW = 6;
    localparam int BN = 8;
    localparam int CL = 2;
    localparam int BS = 8;
    localparam int ST = 5;

    logic pclk;
    logic rst_n;

    vga_pattern_gen_if #(.XW(XW), .YW(YW)) bus ();

    vga_pattern_gen #(
        .H_ADDR(H), .V_ADDR(V), .XW(XW), .YW(YW), .BAR_NUM(BN),
        .CHK_LOG2(CL), .BOX_SIZE(BS), .BOX_STEP(ST)
    ) dut (
        .pclk (pclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [15:0] pal [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    int n_cmp = 0;
    int n_err = 0;

    // Reference state, kept as plain integers.
    int m_active = 0, m_pend = 0, m_fcnt = 0;
    int bx = 0, by = 0;
    bit dxp = 1, dyp = 1;
    bit v_ok = 0, h_ok = 0;
    bit exp_vld = 0, rgb_ok = 0;
    logic [15:0] exp_rgb = '0;
    logic        exp_de = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pix(input int x, input int y);
        int r, g, b;
        case (m_active)
            0: ref_pix = pal[(x / (H / BN)) % 8];
            1: ref_pix = pal[(y / (V / BN)) % 8];
            2: ref_pix = (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            3: begin
                r = (x >> (XW - 5)) & 31;
                g = (y >> (YW - 6)) & 63;
                b = (m_fcnt >> 3) & 31;
                ref_pix = 16'((r << 11) | (g << 5) | b);
            end
            4: ref_pix = (x >= bx && x < bx + BS && y >= by && y < by + BS) ? 16'hFFFF : 16'h001F;
            5: ref_pix = pal[(m_fcnt / 32) % 8];
            default: ref_pix = 16'h0000;
        endcase
    endfunction

    // Bounce with clamp at 0 and at lim; direction flips on touching a limit.
    task automatic step_axis(inout int p, inout bit pos, input int lim);
        if (pos) begin
            if (p + ST >= lim) begin p = lim; pos = 0; end
            else p = p + ST;
        end else begin
            if (p <= ST) begin p = 0; pos = 1; end
            else p = p - ST;
        end
    endtask

    // One pclk: check the previous cycle's outputs, drive this cycle, advance the model.
    task automatic cyc(input logic r, input logic d, input int x, input int y,
                       input logic wr, input logic [2:0] mi);
        bit fe;
        @(negedge pclk);
        if (exp_vld) begin
            chk("data_de", {15'd0, bus.data_de}, {15'd0, exp_de});
            if (rgb_ok) chk("data_rgb", bus.data_rgb, exp_rgb);
            chk("frame_cnt", {8'd0, bus.frame_cnt}, 16'(m_fcnt));
        end
        rst_n       = r;
        bus.de      = d;
        bus.X       = XW'(x);
        bus.Y       = YW'(y);
        bus.mode_wr = wr;
        bus.mode_in = mi;
        if (!r) begin
            exp_de = 0; exp_rgb = '0; rgb_ok = 1;
            m_active = 0; m_pend = 0; m_fcnt = 0;
            bx = 0; by = 0; dxp = 1; dyp = 1;
            v_ok = 0; h_ok = 0;
        end else begin
            if (d && x == 0) v_ok = 1;
            if (d && y == 0) h_ok = 1;
            exp_de  = d;
            exp_rgb = d ? ref_pix(x, y) : 16'h0000;
            rgb_ok  = !d || (m_active == 0 ? v_ok : (m_active == 1 ? h_ok : 1'b1));
            fe = d && x == H - 1 && y == V - 1;
            if (fe) begin
                m_active = wr ? int'(mi) : m_pend;
                m_fcnt   = (m_fcnt + 1) % 256;
                step_axis(bx, dxp, H - BS);
                step_axis(by, dyp, V - BS);
            end
            if (wr) m_pend = int'(mi);
        end
        exp_vld = 1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            cyc(1, 0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 0, 3'd0);
    endtask

    // Full raster; w1/w2 are pixel indices of mode writes (-1 = none), we adds one at frame_end.
    task automatic frame_run(input bit de_on, input int w1, input logic [2:0] m1,
                             input int w2, input logic [2:0] m2,
                             input bit we, input logic [2:0] me);
        int idx;
        logic wr;
        logic [2:0] mi;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                idx = y * H + x;
                wr = 0; mi = 3'd0;
                if (idx == w1) begin wr = 1; mi = m1; end
                if (idx == w2) begin wr = 1; mi = m2; end
                if (we && idx == H * V - 1) begin wr = 1; mi = me; end
                cyc(1, de_on, x, y, wr, mi);
            end
            blank(3);
        end
    endtask

    // Only the frame_end pixel is presented; bar counters are stale for this pixel.
    task automatic fast_frame(input logic wr, input logic [2:0] mi);
        v_ok = 0; h_ok = 0;
        cyc(1, 1, H - 1, V - 1, wr, mi);
        blank(2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.de = 1'b0; bus.X = '0; bus.Y = '0; bus.mode_in = '0; bus.mode_wr = 1'b0;

        repeat (3) cyc(0, 0, 0, 0, 0, 3'd0);
        blank(2);
        // Mid-frame line, reset asserted mid-line with de high.
        for (int x = 0; x < H / 2; x++) cyc(1, 1, x, 5, 0, 3'd0);
        cyc(0, 1, H / 2, 5, 0, 3'd0);
        cyc(0, 1, H / 2 + 1, 5, 0, 3'd0);
        for (int x = H / 2 + 2; x < H; x++) cyc(1, 1, x, 5, 0, 3'd0);
        blank(3);

        frame_run(1, 100, 3'd2, -1, 3'd0, 0, 3'd0);   // VBAR, CHECK queued
        frame_run(1, -1, 3'd0, -1, 3'd0, 1, 3'd1);    // CHECK, HBAR bypassed at frame_end
        frame_run(1, 50, 3'd3, 300, 3'd4, 0, 3'd0);   // HBAR, last write (BOX) wins
        repeat (12) frame_run(1, -1, 3'd0, -1, 3'd0, 0, 3'd0);
        frame_run(1, 17, 3'd3, -1, 3'd0, 0, 3'd0);
        frame_run(1, 200, 3'd5, -1, 3'd0, 0, 3'd0);
        frame_run(1, 9, 3'd6, -1, 3'd0, 0, 3'd0);
        frame_run(1, 400, 3'd7, -1, 3'd0, 0, 3'd0);
        frame_run(0, 33, 3'd2, -1, 3'd0, 1, 3'd4);    // de low: no frame_end, pending only
        frame_run(1, -1, 3'd0, -1, 3'd0, 0, 3'd0);    // mode 7, then pending applies
        frame_run(1, -1, 3'd0, -1, 3'd0, 0, 3'd0);
        repeat (6)
            frame_run(1, $urandom_range(0, 1) ? int'($urandom_range(0, H * V - 2)) : -1,
                      3'($urandom_range(0, 7)),
                      $urandom_range(0, 1) ? int'($urandom_range(0, H * V - 2)) : -1,
                      3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

        fast_frame(1, 3'd5);
        repeat (140) fast_frame(0, 3'd0);
        fast_frame(1, 3'd3);
        repeat (130) fast_frame(0, 3'd0);
        fast_frame(1, 3'd1);
        frame_run(1, -1, 3'd0, -1, 3'd0, 1, 3'd3);    // HBAR after resync
        frame_run(1, -1, 3'd0, -1, 3'd0, 0, 3'd0);    // GRAD after frame_cnt wrap
        blank(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
